// File: rtl/puller.sv
// puller: pull-driven FIFO buffer between a valid/ready pusher
// and a consumer that requests one item at a time.
module puller #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         item_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     pull,
  output logic [WIDTH-1:0]         item_out,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_item_out;
  logic             r_out_valid;
  logic [7:0]       r_drop;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pull;
  logic w_drop;

  // status flags come from the registered level only
  always_comb begin
    w_full  = (r_level == (AW+1)'(DEPTH));
    w_empty = (r_level == '0);
    w_push  = in_valid & ~w_full;
    w_pull  = pull & ~w_empty;
    w_drop  = in_valid & w_full;
  end

  // storage array; entries are only read after being written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= item_in;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pull) r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        (w_push & ~w_pull): r_level <= r_level + (AW+1)'(1);
        (~w_push & w_pull): r_level <= r_level - (AW+1)'(1);
        default:            r_level <= r_level;
      endcase
    end
  end

  // registered delivery: one pulse per accepted pull
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_item_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_pull;
      if (w_pull) r_item_out <= r_mem[r_rptr];
    end
  end

  // saturating count of items refused while full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop <= 8'd0;
    end else if (w_drop && r_drop != 8'hFF) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign in_ready   = ~w_full;
  assign item_out   = r_item_out;
  assign out_valid  = r_out_valid;
  assign level      = r_level;
  assign empty      = w_empty;
  assign full       = w_full;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_puller.sv
// tb_puller: scoreboard bench for the puller buffer.
// Model tracks level, drops and expected delivery order.
module tb_puller;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] item_in;
  logic       in_valid;
  logic       in_ready;
  logic       pull;
  logic [7:0] item_out;
  logic       out_valid;
  logic [2:0] level;
  logic       empty;
  logic       full;
  logic [7:0] drop_count;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  int         m_level = 0;
  int         m_drop = 0;
  bit         m_exp_ov = 1'b0;
  logic [7:0] m_item = 8'h00;

  puller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .item_in(item_in), .in_valid(in_valid),
    .in_ready(in_ready), .pull(pull),
    .item_out(item_out), .out_valid(out_valid),
    .level(level), .empty(empty), .full(full),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // scoreboard: every delivery pulse pops the oldest pushed item
  always @(negedge clk) begin
    logic [7:0] exp;
    n_tests++;
    if (out_valid !== m_exp_ov) begin
      n_fail++;
      $display("FAIL sb_out_valid got=%b want=%b t=%0t",
               out_valid, m_exp_ov, $time);
    end
    if (m_exp_ov) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      m_item = exp;
      n_tests++;
      if (item_out !== exp) begin
        n_fail++;
        $display("FAIL sb_item got=%h want=%h t=%0t",
                 item_out, exp, $time);
      end
    end
  end

  task automatic step();
    bit p;
    bit q;
    logic [7:0] d;
    p = in_valid && (m_level < DEPTH);
    q = pull && (m_level > 0);
    d = item_in;
    if (in_valid && m_level == DEPTH && m_drop < 255) m_drop++;
    @(posedge clk);
    if (p) sb.push_back(d);
    m_level = m_level + int'(p) - int'(q);
    m_exp_ov = q;
    #1;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    sb.delete();
    m_level = 0;
    m_drop = 0;
    m_exp_ov = 1'b0;
    m_item = 8'h00;
    in_valid = 1'b0;
    pull = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    pull = 1'b0;
    item_in = 8'h00;
    #1;
    n_tests++;
    if ({in_ready, empty, full, out_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rst_flags got=%b want=1100",
               {in_ready, empty, full, out_valid});
    end
    n_tests++;
    if (level !== 3'd0 || item_out !== 8'h00 || drop_count !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_vals got=%0d/%h/%0d want=0/00/0",
               level, item_out, drop_count);
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      item_in = 8'(i);
      step();
    end
    in_valid = 1'b0;
    n_tests++;
    if (level !== 3'd3 || empty !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL fill3 got=%0d/%b/%b want=3/0/0", level, empty, full);
    end
    pull = 1'b1;
    repeat (3) step();
    pull = 1'b0;
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain3_empty got=%b want=1", empty);
    end
  endtask

  task automatic test_full();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      item_in = 8'h10 + 8'(i);
      step();
    end
    n_tests++;
    if (full !== 1'b1 || in_ready !== 1'b0 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL full4 got=%b/%b/%0d want=1/0/4", full, in_ready, level);
    end
    item_in = 8'h14;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (drop_count !== 8'd1 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL drop1 got=%0d/%0d want=1/4", drop_count, level);
    end
    pull = 1'b1;
    repeat (4) step();
    pull = 1'b0;
    step();
    n_tests++;
    if (empty !== 1'b1 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL full_drain got=%b/%0d want=1/0", empty, level);
    end
  endtask

  task automatic test_stream();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      item_in = 8'h20 + 8'(i);
      pull = (i >= 1);
      step();
      n_tests++;
      if (level !== 3'd1) begin
        n_fail++;
        $display("FAIL stream_level i=%0d got=%0d want=1", i, level);
      end
      if (i >= 1) begin
        n_tests++;
        if (out_valid !== 1'b1 || item_out !== 8'h20 + 8'(i - 1)) begin
          n_fail++;
          $display("FAIL stream_out i=%0d got=%b/%h want=1/%h",
                   i, out_valid, item_out, 8'h20 + 8'(i - 1));
        end
      end
    end
    in_valid = 1'b0;
    step();
    pull = 1'b0;
    step();
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_empty got=%b want=1", empty);
    end
  endtask

  task automatic test_empty_push_pull();
    in_valid = 1'b1;
    item_in = 8'h55;
    pull = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || level !== 3'd1) begin
      n_fail++;
      $display("FAIL epp_first got=%b/%0d want=0/1", out_valid, level);
    end
    in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || item_out !== 8'h55) begin
      n_fail++;
      $display("FAIL epp_pull got=%b/%h want=1/55", out_valid, item_out);
    end
    pull = 1'b0;
    step();
  endtask

  task automatic test_pull_empty_saturate();
    pull = 1'b1;
    repeat (3) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0 || item_out !== 8'h55) begin
        n_fail++;
        $display("FAIL pull_empty got=%b/%h want=0/55", out_valid, item_out);
      end
    end
    pull = 1'b0;
    in_valid = 1'b1;
    item_in = 8'h66;
    repeat (304) step();
    in_valid = 1'b0;
    n_tests++;
    if (drop_count !== 8'd255 || drop_count !== 8'(m_drop) || full !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_sat got=%0d/%b want=255/1", drop_count, full);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      pull = 1'($urandom_range(0, 1));
      item_in = 8'($urandom);
      step();
      n_tests++;
      if (level !== 3'(m_level) || full !== (m_level == DEPTH) ||
          empty !== (m_level == 0) || in_ready !== (m_level != DEPTH)) begin
        n_fail++;
        $display("FAIL b2b_state i=%0d got=%0d/%b/%b want=%0d",
                 i, level, full, empty, m_level);
      end
    end
    in_valid = 1'b0;
    pull = 1'b0;
    n_tests++;
    if (drop_count !== 8'(m_drop)) begin
      n_fail++;
      $display("FAIL b2b_drops got=%0d want=%0d", drop_count, m_drop);
    end
    pull = 1'b1;
    repeat (5) step();
    pull = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    item_in = 8'hA1;
    step();
    item_in = 8'hA2;
    step();
    in_valid = 1'b0;
    pull = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || item_out !== 8'hA1 || level !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_pre got=%b/%h/%0d want=1/a1/1",
               out_valid, item_out, level);
    end
    #1;
    reset = 1'b0;
    sb.delete();
    m_level = 0;
    m_drop = 0;
    m_exp_ov = 1'b0;
    m_item = 8'h00;
    pull = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, empty, full, out_valid} !== 4'b1100 ||
        level !== 3'd0 || item_out !== 8'h00 || drop_count !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst got=%b/%0d/%h/%0d",
               {in_ready, empty, full, out_valid}, level, item_out, drop_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) step();
    n_tests++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after got=%0d/%b want=0/0", level, out_valid);
    end
    in_valid = 1'b1;
    item_in = 8'h77;
    step();
    in_valid = 1'b0;
    pull = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || item_out !== 8'h77) begin
      n_fail++;
      $display("FAIL mid_repush got=%b/%h want=1/77", out_valid, item_out);
    end
    pull = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_stream();
    test_empty_push_pull();
    test_pull_empty_saturate();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
